// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues imem word requests,
// buffers returned words in an in-order queue and presents the head to IF/ID.
//
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   imem_req_valid/addr, imem_req_ready    request channel to instruction memory
//   imem_resp_valid/data                   in-order response words
//   redirect_valid/pc                  flush and restart (taken branch / jump)
//   stall_d                            decode cannot accept the head
//   instr_valid_d, instr_d, pc_d, pc_plus4_d   queue head towards decode
module fetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall_d,
    output logic        instr_valid_d,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [AW-1:0] ptr_t;

    logic [31:0] instr_q  [DEPTH];
    logic [31:0] pc_q     [DEPTH];
    logic [31:0] shadow_q [DEPTH];

    ptr_t        head;
    ptr_t        tail;
    ptr_t        sh_rd;
    ptr_t        sh_wr;
    cnt_t        count;
    cnt_t        inflight;
    cnt_t        drop;
    cnt_t        inflight_next;
    logic [31:0] fetch_pc;
    logic [31:0] last_pc;
    logic [CW:0] used;

    logic accept;
    logic push;
    logic pop;

    // Every outstanding request reserves a queue slot, so the queue
    // can never overflow when its responses come back.
    assign used           = {1'b0, count} + {1'b0, inflight};
    assign imem_req_valid = !rst && !redirect_valid
                            && (used < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;

    assign accept = imem_req_valid && imem_req_ready;
    assign push   = imem_resp_valid && (drop == '0) && !redirect_valid;
    assign pop    = instr_valid_d && !stall_d && !redirect_valid;

    assign inflight_next = inflight + cnt_t'(accept)
                           - cnt_t'(imem_resp_valid);

    assign instr_valid_d = (count != '0);
    assign instr_d       = instr_valid_d ? instr_q[head] : NOP;
    assign pc_d          = instr_valid_d ? pc_q[head] : last_pc;
    assign pc_plus4_d    = pc_d + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            sh_rd    <= '0;
            sh_wr    <= '0;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
            last_pc  <= '0;
        end else begin
            last_pc  <= pc_d;
            inflight <= inflight_next;

            // The shadow FIFO tracks the PC of every outstanding request,
            // including ones whose responses will be dropped.
            if (accept) begin
                shadow_q[sh_wr] <= fetch_pc;
                sh_wr           <= sh_wr + ptr_t'(1);
            end
            if (imem_resp_valid) begin
                sh_rd <= sh_rd + ptr_t'(1);
            end

            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ~32'd3;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                // Everything still outstanding after this edge is stale.
                drop     <= inflight_next;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (imem_resp_valid && (drop != '0)) begin
                    drop <= drop - cnt_t'(1);
                end
                if (push) begin
                    instr_q[tail] <= imem_resp_data;
                    pc_q[tail]    <= shadow_q[sh_rd];
                    tail          <= tail + ptr_t'(1);
                end
                if (pop) begin
                    head <= head + ptr_t'(1);
                end
                count <= count + cnt_t'(push) - cnt_t'(pop);
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && count == cnt_t'(DEPTH)));
            assert (!(imem_resp_valid && inflight == '0));
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: random memory latency/ready,
// stalls, redirects and resets, checked against an in-order PC-stream model.
module tb_fetch_prefetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall_d;
    logic        instr_valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;

    always #5 clk = ~clk;

    fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_d        (stall_d),
        .instr_valid_d  (instr_valid_d),
        .instr_d        (instr_d),
        .pc_d           (pc_d),
        .pc_plus4_d     (pc_plus4_d)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       pend[$];
    logic [31:0] sb[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int accepts  = 0;
    int pops     = 0;
    int last_due = 0;
    int lat_min  = 1;
    int lat_max  = 1;
    int ready_pct = 100;
    logic [31:0] model_pc = 32'h0;

    logic        n_rst   = 1'b1;
    logic        n_stall = 1'b0;
    logic        n_redir = 1'b0;
    logic [31:0] n_rpc   = 32'h0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, then record any
    // request the DUT has accepted before the next edge.
    task automatic step();
        int lat;
        int due;
        @(posedge clk);
        cyc++;
        #1;
        rst            = n_rst;
        stall_d        = n_stall;
        redirect_valid = n_redir;
        redirect_pc    = n_rpc;
        imem_req_ready = ($urandom_range(99) < ready_pct);
        if (n_rst) begin
            sb.delete();
            pend.delete();
            model_pc = 32'h0;
            last_due = 0;
        end else if (n_redir) begin
            sb.delete();
            model_pc = n_rpc & ~32'd3;
        end
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        if (!n_rst && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = memf(pend[0].addr);
            void'(pend.pop_front());
        end
        #3;
        if (n_rst || n_redir) begin
            chk("req_blocked", {31'b0, imem_req_valid}, 32'd0);
        end
        if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, model_pc);
            accepts++;
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{addr: model_pc, due: due});
            sb.push_back(model_pc);
            model_pc = model_pc + 32'd4;
        end
    endtask

    // Monitor: every word decode consumes must be the next PC of the
    // current stream, carrying the word memory holds at that PC.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst === 1'b0) begin
            if (instr_valid_d) begin
                if (!stall_d && !redirect_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL spurious_head: pc %h with no expected entry",
                                 pc_d);
                    end else begin
                        e = sb.pop_front();
                        chk("head_pc", pc_d, e);
                        chk("head_instr", instr_d, memf(e));
                        chk("head_pc_plus4", pc_plus4_d, e + 32'd4);
                        pops++;
                    end
                end
            end else begin
                chk("nop_when_empty", instr_d, NOP);
            end
        end
    end

    initial begin
        rst             = 1'b1;
        stall_d         = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;

        // Reset and the initial sequential stream from RESET_PC.
        n_rst = 1'b1;
        step();
        n_rst = 1'b0;
        step();
        chk("rst_valid", {31'b0, instr_valid_d}, 32'd0);
        chk("rst_instr", instr_d, NOP);
        chk("rst_pc", pc_d, 32'h0);
        chk("rst_pc_plus4", pc_plus4_d, 32'h4);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
        step();
        step();
        chk("first_head_valid", {31'b0, instr_valid_d}, 32'd1);
        chk("first_head_pc", pc_d, 32'h0);
        repeat (8) step();

        // Decode stalled: exactly DEPTH requests, then credit runs out.
        n_stall = 1'b1;
        n_redir = 1'b1;
        n_rpc   = 32'h200;
        step();
        n_redir = 1'b0;
        begin
            int a0;
            a0 = accepts;
            repeat (10) step();
            chk("stall_req_count", 32'(accepts - a0), 32'd4);
        end
        chk("full_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("full_head_valid", {31'b0, instr_valid_d}, 32'd1);
        n_stall = 1'b0;
        repeat (20) step();

        // Redirect with three requests in flight at 3-cycle latency.
        lat_min = 3;
        lat_max = 3;
        repeat (10) step();
        n_redir = 1'b1;
        n_rpc   = 32'h100;
        step();
        n_redir = 1'b0;
        repeat (20) step();

        // Redirect coinciding with a response and a pop.
        lat_min = 1;
        lat_max = 1;
        repeat (6) step();
        n_redir = 1'b1;
        n_rpc   = 32'h100;
        step();
        n_redir = 1'b0;
        step();
        chk("flush_empty", {31'b0, instr_valid_d}, 32'd0);
        chk("flush_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("flush_req_addr", imem_req_addr, 32'h100);
        repeat (10) step();

        // Fetch PC wrapping past the top of the address space.
        n_redir = 1'b1;
        n_rpc   = 32'hFFFF_FFFE;
        step();
        n_redir = 1'b0;
        repeat (15) step();

        // Reset with requests outstanding.
        lat_min = 3;
        lat_max = 3;
        repeat (5) step();
        n_rst = 1'b1;
        step();
        n_rst = 1'b0;
        step();
        chk("rst2_valid", {31'b0, instr_valid_d}, 32'd0);
        chk("rst2_instr", instr_d, NOP);
        repeat (15) step();

        // Random traffic.
        lat_min   = 1;
        lat_max   = 4;
        ready_pct = 70;
        for (int i = 0; i < 1500; i++) begin
            n_stall = ($urandom_range(99) < 25);
            n_redir = ($urandom_range(99) < 3);
            n_rst   = ($urandom_range(999) < 5);
            n_rpc   = ($urandom_range(3) == 0)
                      ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                      : 32'($urandom);
            step();
        end
        n_stall = 1'b0;
        n_redir = 1'b0;
        n_rst   = 1'b0;
        repeat (20) step();

        checks++;
        if (pops < 300) begin
            failures++;
            $display("FAIL throughput: %0d words consumed, need at least 300",
                     pops);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
